// File: rtl/multi_pipeline_control_unit_pkg.sv
// Shared opcodes, response codes, FSM encoding and payload sizing helpers
// for the multi-pipeline command decoder.
package multi_pipeline_control_unit_pkg;
  localparam int BLOCK_INSTR_WIDTH = 32;

  localparam logic [3:0] OP_WRITE_INSTR  = 4'h1;
  localparam logic [3:0] OP_WRITE_REG0   = 4'h2;
  localparam logic [3:0] OP_WRITE_REG1   = 4'h3;
  localparam logic [3:0] OP_UPDATE_REG0  = 4'h4;
  localparam logic [3:0] OP_UPDATE_REG1  = 4'h5;
  localparam logic [3:0] OP_ALLOC_DELAY  = 4'h6;
  localparam logic [3:0] OP_SWAP         = 4'h7;
  localparam logic [3:0] OP_RESET_PIPE   = 4'h8;
  localparam logic [3:0] OP_COMMIT       = 4'h9;
  localparam logic [3:0] OP_SET_IN_GAIN  = 4'hA;
  localparam logic [3:0] OP_SET_OUT_GAIN = 4'hB;
  localparam logic [3:0] OP_PING         = 4'hC;

  localparam logic [7:0] RESP_ACK       = 8'h00;
  localparam logic [7:0] RESP_BAD_OP    = 8'h01;
  localparam logic [7:0] RESP_BAD_PIPE  = 8'h02;
  localparam logic [7:0] RESP_TIMEOUT   = 8'h03;
  localparam logic [7:0] RESP_SAME_PIPE = 8'h04;

  typedef enum logic [2:0] {
    ST_READY, ST_LISTEN, ST_EXECUTE, ST_SWAP_WAIT, ST_RESET_WAIT
  } state_t;

  // Whole bytes needed to carry a field, never fewer than one.
  function automatic int bytes_for_bits(input int bits);
    int b;
    b = (bits + 7) / 8;
    return (b < 1) ? 1 : b;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Payload bytes following the command byte for each opcode.
  function automatic int payload_len(input logic [3:0] op, input int bb,
                                     input int db, input int dab);
    case (op)
      OP_WRITE_INSTR:                  return bb + 4;
      OP_WRITE_REG0, OP_WRITE_REG1,
      OP_UPDATE_REG0, OP_UPDATE_REG1:  return bb + db;
      OP_ALLOC_DELAY:                  return 2 * dab;
      OP_SET_IN_GAIN, OP_SET_OUT_GAIN: return db;
      default:                         return 0;
    endcase
  endfunction
endpackage

// File: rtl/multi_pipeline_control_unit_if.sv
// Host byte link: command bytes in, one-byte ACK/NACK responses out.
interface multi_pipeline_control_unit_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] resp_byte;
  logic       resp_valid;
  logic       invalid;

  modport master (output in_byte, in_valid, input in_ready, resp_byte, resp_valid, invalid);
  modport slave  (input in_byte, in_valid, output in_ready, resp_byte, resp_valid, invalid);
endinterface

// File: rtl/multi_pipeline_control_unit_cmd_payload_shifter.sv
// Collects payload bytes big-endian and watches for a stalled host.
module cmd_payload_shifter #(
  parameter int SH_BYTES = 6,
  parameter int CW       = 3,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  listening,
  input  logic                  accept,
  input  logic [7:0]            in_byte,
  input  logic [CW-1:0]         need,
  output logic [8*SH_BYTES-1:0] shreg,
  output logic                  last_byte,
  output logic                  timed_out
);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idle;

  assign last_byte = accept && (cnt == need - CW'(1));
  assign timed_out = listening && !accept && (idle == IW'(TIMEOUT - 1));

  // Byte count and idle count restart while idle; bytes shift in from the low end.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      idle  <= '0;
      shreg <= '0;
    end else if (start) begin
      cnt  <= '0;
      idle <= '0;
    end else if (accept) begin
      cnt   <= cnt + CW'(1);
      idle  <= '0;
      shreg <= {shreg[8*SH_BYTES-9:0], in_byte};
    end else if (listening) begin
      idle <= idle + IW'(1);
    end
  end
endmodule

// File: rtl/multi_pipeline_control_unit.sv
// Command decoder/sequencer driving N pipelines from a host byte stream.
module multi_pipeline_control_unit
  import multi_pipeline_control_unit_pkg::*;
#(
  parameter int n_blocks         = 256,
  parameter int n_pipelines      = 2,
  parameter int data_width       = 16,
  parameter int delay_addr_bytes = 3,
  parameter int timeout_cycles   = 1000000
) (
  input  logic                          clk,
  input  logic                          reset,
  multi_pipeline_control_unit_if.slave  link,
  output logic [$clog2(n_blocks)-1:0]   block_target,
  output logic                          reg_target,
  output logic [BLOCK_INSTR_WIDTH-1:0]  instr_out,
  output logic [data_width-1:0]         data_out,
  output logic [8*delay_addr_bytes-1:0] delay_size_out,
  output logic [8*delay_addr_bytes-1:0] init_delay_out,
  output logic [n_pipelines-1:0]        block_instr_write,
  output logic [n_pipelines-1:0]        block_reg_write,
  output logic [n_pipelines-1:0]        reg_writes_commit,
  input  logic [n_pipelines-1:0]        pipeline_regfiles_syncing,
  output logic [n_pipelines-1:0]        alloc_delay,
  output logic [n_pipelines-1:0]        pipeline_full_reset,
  input  logic [n_pipelines-1:0]        pipeline_resetting,
  output logic [n_pipelines-1:0]        pipeline_enables,
  output logic                          swap_pipelines,
  output logic [$clog2(n_pipelines)-1:0] swap_target,
  input  logic                          pipelines_swapping,
  output logic [$clog2(n_pipelines)-1:0] current_pipeline,
  output logic                          set_input_gain,
  output logic                          set_output_gain
);
  localparam int NP   = n_pipelines;
  localparam int BB   = bytes_for_bits($clog2(n_blocks));
  localparam int DB   = bytes_for_bits(data_width);
  localparam int DAB  = delay_addr_bytes;
  localparam int MAXB = max3(BB + 4, BB + DB, 2 * DAB);
  localparam int CW   = $clog2(MAXB + 1);
  localparam int BT_W = $clog2(n_blocks);

  localparam logic [NP-1:0] ONE = {{(NP-1){1'b0}}, 1'b1};

  state_t          state;
  logic            arm, rst_q;
  logic [3:0]      cmd_op, cmd_p;
  logic [NP-1:0]   pend_commit, p_mask, in_mask, cur_mask;
  logic [7:0]      resp_byte_q;
  logic            resp_valid_q, invalid_q;
  logic [8*MAXB-1:0] shreg;
  logic            last_byte, timed_out, accept, stall;
  logic [3:0]      in_op, in_p;

  assign in_op         = link.in_byte[7:4];
  assign in_p          = link.in_byte[3:0];
  assign link.in_ready = (state == ST_READY) || (state == ST_LISTEN);
  assign link.resp_byte  = resp_byte_q;
  assign link.resp_valid = resp_valid_q;
  assign link.invalid    = invalid_q;
  assign accept   = (state == ST_LISTEN) && link.in_valid;
  assign p_mask   = ONE << cmd_p;
  assign in_mask  = ONE << in_p;
  assign cur_mask = ONE << current_pipeline;
  assign stall    = pipelines_swapping || |(pipeline_regfiles_syncing & p_mask);

  cmd_payload_shifter #(.SH_BYTES(MAXB), .CW(CW), .TIMEOUT(timeout_cycles)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .start     (state == ST_READY),
    .listening (state == ST_LISTEN),
    .accept    (accept),
    .in_byte   (link.in_byte),
    .need      (CW'(payload_len(cmd_op, BB, DB, DAB))),
    .shreg     (shreg),
    .last_byte (last_byte),
    .timed_out (timed_out)
  );

  // Delayed copy of reset so every reset edge is followed by a full pipeline reset.
  always_ff @(posedge clk) rst_q <= reset;

  // Command sequencer: decode, collect payload, execute, swap/reset handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_READY;
      arm <= 1'b0; cmd_op <= '0; cmd_p <= '0; pend_commit <= '0;
      current_pipeline <= '0; swap_target <= '0; pipeline_enables <= ONE;
      block_target <= '0; reg_target <= 1'b0; instr_out <= '0; data_out <= '0;
      delay_size_out <= '0; init_delay_out <= '0;
      block_instr_write <= '0; block_reg_write <= '0; reg_writes_commit <= '0;
      alloc_delay <= '0; pipeline_full_reset <= {NP{rst_q}}; swap_pipelines <= 1'b0;
      set_input_gain <= 1'b0; set_output_gain <= 1'b0;
      resp_byte_q <= '0; resp_valid_q <= 1'b0; invalid_q <= 1'b0;
    end else begin
      block_instr_write <= '0; block_reg_write <= '0; alloc_delay <= '0;
      reg_writes_commit <= pend_commit; pend_commit <= '0;
      pipeline_full_reset <= {NP{rst_q}}; swap_pipelines <= 1'b0;
      set_input_gain <= 1'b0; set_output_gain <= 1'b0;
      resp_valid_q <= 1'b0; invalid_q <= 1'b0;
      case (state)
        ST_READY: if (link.in_valid) begin
          cmd_op <= in_op;
          cmd_p  <= in_p;
          if (in_op == 4'h0 || in_op > OP_PING) begin
            resp_valid_q <= 1'b1; resp_byte_q <= RESP_BAD_OP; invalid_q <= 1'b1;
          end else if (in_op < OP_SET_IN_GAIN && {1'b0, in_p} >= 5'(NP)) begin
            resp_valid_q <= 1'b1; resp_byte_q <= RESP_BAD_PIPE; invalid_q <= 1'b1;
          end else begin
            case (in_op)
              OP_RESET_PIPE: pipeline_full_reset <= {NP{rst_q}} | in_mask;
              OP_COMMIT:     reg_writes_commit <= pend_commit | in_mask;
              OP_PING: begin
                resp_valid_q <= 1'b1; resp_byte_q <= RESP_ACK;
              end
              OP_SWAP: begin
                if (in_p == 4'(current_pipeline)) begin
                  resp_valid_q <= 1'b1; resp_byte_q <= RESP_SAME_PIPE; invalid_q <= 1'b1;
                end else begin
                  swap_pipelines    <= 1'b1;
                  reg_writes_commit <= pend_commit | in_mask;
                  pipeline_enables  <= pipeline_enables | in_mask;
                  swap_target       <= in_p[$clog2(NP)-1:0];
                  arm   <= 1'b0;
                  state <= ST_SWAP_WAIT;
                end
              end
              default: state <= ST_LISTEN;
            endcase
          end
        end
        ST_LISTEN: begin
          if (timed_out) begin
            resp_valid_q <= 1'b1; resp_byte_q <= RESP_TIMEOUT; invalid_q <= 1'b1;
            state <= ST_READY;
          end else if (last_byte) begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (!(cmd_op >= OP_WRITE_REG0 && cmd_op <= OP_UPDATE_REG1 && stall)) begin
            resp_valid_q <= 1'b1; resp_byte_q <= RESP_ACK;
            state <= ST_READY;
          end
          case (cmd_op)
            OP_WRITE_INSTR: begin
              instr_out         <= shreg[BLOCK_INSTR_WIDTH-1:0];
              block_target      <= shreg[32 +: BT_W];
              block_instr_write <= p_mask;
            end
            OP_WRITE_REG0, OP_WRITE_REG1, OP_UPDATE_REG0, OP_UPDATE_REG1: if (!stall) begin
              data_out        <= shreg[data_width-1:0];
              block_target    <= shreg[8*DB +: BT_W];
              reg_target      <= cmd_op[0];
              block_reg_write <= p_mask;
              if (cmd_op >= OP_UPDATE_REG0) pend_commit <= p_mask;
            end
            OP_ALLOC_DELAY: begin
              init_delay_out <= shreg[8*DAB-1:0];
              delay_size_out <= shreg[8*DAB +: 8*DAB];
              alloc_delay    <= p_mask;
            end
            OP_SET_IN_GAIN: begin
              data_out <= shreg[data_width-1:0]; set_input_gain <= 1'b1;
            end
            default: begin
              data_out <= shreg[data_width-1:0]; set_output_gain <= 1'b1;
            end
          endcase
        end
        ST_SWAP_WAIT: begin
          arm <= 1'b1;
          if (arm && !pipelines_swapping) begin
            current_pipeline    <= swap_target;
            pipeline_full_reset <= {NP{rst_q}} | cur_mask;
            pipeline_enables    <= pipeline_enables & ~cur_mask;
            arm   <= 1'b0;
            state <= ST_RESET_WAIT;
          end
        end
        default: begin
          arm <= 1'b1;
          if (arm && !(|pipeline_resetting)) begin
            resp_valid_q <= 1'b1; resp_byte_q <= RESP_ACK;
            state <= ST_READY;
          end
        end
      endcase
    end
  end
endmodule
